// File: rtl/frame_rate_shaper_if.sv
// AXI-Stream style beat interface used on both sides of the frame rate shaper.
//   valid/ready/last : handshake and end-of-frame marker
//   data             : DATA_WIDTH-bit beat payload
//   keep/user        : DATA_WIDTH/8 bits each, one bit per byte lane
//   id               : 3-bit stream identifier
// master drives the beat and samples ready; slave samples the beat and drives ready.
interface frame_rate_shaper_if #(
    parameter int DATA_WIDTH = 512
);
    logic                    valid;
    logic                    ready;
    logic                    last;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] keep;
    logic [DATA_WIDTH/8-1:0] user;
    logic [2:0]              id;

    modport master (
        output valid, last, data, keep, user, id,
        input  ready
    );

    modport slave (
        input  valid, last, data, keep, user, id,
        output ready
    );
endinterface

// File: rtl/frame_rate_shaper.sv
// Frame rate shaper: passes AXI-Stream frames through a one-entry output
// register and inserts a programmable number of idle input cycles after
// each frame's last beat.
//   clk         : sole clock, rising edge
//   rst         : synchronous, active-low reset
//   start       : pulse, begins shaping from IDLE and clears both counters
//   stop        : pulse, ends shaping at the next frame boundary
//   gap_cycles  : idle input cycles after each frame, sampled on the last beat
//   axis_s      : upstream beat stream (slave side)
//   axis_m      : downstream beat stream (master side), registered
//   frame_count : frames whose last beat was accepted since the last start
//   gap_count   : cycles spent in GAP since the last start
//   busy        : high whenever the shaper is not IDLE
module frame_rate_shaper #(
    parameter int DATA_WIDTH = 512,
    parameter int GAP_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [GAP_WIDTH-1:0] gap_cycles,
    frame_rate_shaper_if.slave   axis_s,
    frame_rate_shaper_if.master  axis_m,
    output logic [31:0]          frame_count,
    output logic [31:0]          gap_count,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        GAP   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t               state, state_next;
    logic [GAP_WIDTH-1:0] gap_cnt, gap_cnt_next;
    logic                 mid_frame;
    logic                 frame_open;
    logic                 clr_counters;
    logic                 inc_gap;

    logic                    m_valid_q;
    logic                    m_last_q;
    logic [DATA_WIDTH-1:0]   m_data_q;
    logic [DATA_WIDTH/8-1:0] m_keep_q;
    logic [DATA_WIDTH/8-1:0] m_user_q;
    logic [2:0]              m_id_q;

    logic s_ready;
    logic accept;
    logic accept_last;

    // The output register can take a new beat when empty or emptying this cycle.
    assign s_ready     = ((state == PASS) || (state == DRAIN)) && (!m_valid_q || axis_m.ready);
    assign accept      = axis_s.valid && s_ready;
    assign accept_last = accept && axis_s.last;

    // A frame is still open after this cycle if a non-last beat goes in now,
    // or one went in earlier and the closing beat is not arriving now.
    assign frame_open = accept ? !axis_s.last : mid_frame;

    always_comb begin
        state_next   = state;
        gap_cnt_next = gap_cnt;
        clr_counters = 1'b0;
        inc_gap      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_next   = PASS;
                    clr_counters = 1'b1;
                end
            end
            PASS: begin
                if (stop) begin
                    state_next = frame_open ? DRAIN : IDLE;
                end else if (accept_last && (gap_cycles != '0)) begin
                    state_next   = GAP;
                    gap_cnt_next = gap_cycles;
                end
            end
            GAP: begin
                inc_gap = 1'b1;
                if (stop) begin
                    state_next   = IDLE;
                    gap_cnt_next = '0;
                end else begin
                    if (gap_cnt != '0) begin
                        gap_cnt_next = gap_cnt - GAP_WIDTH'(1);
                    end
                    if (gap_cnt <= GAP_WIDTH'(1)) begin
                        state_next = PASS;
                    end
                end
            end
            DRAIN: begin
                if (accept_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            mid_frame <= 1'b0;
        end else begin
            state   <= state_next;
            gap_cnt <= gap_cnt_next;
            if (accept) begin
                mid_frame <= !axis_s.last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_count <= '0;
            gap_count   <= '0;
        end else if (clr_counters) begin
            frame_count <= '0;
            gap_count   <= '0;
        end else begin
            if (accept_last) begin
                frame_count <= frame_count + 32'd1;
            end
            if (inc_gap) begin
                gap_count <= gap_count + 32'd1;
            end
        end
    end

    // Valid tracks only the handshake, so a held beat keeps draining in GAP and IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_valid_q <= 1'b0;
        end else if (accept) begin
            m_valid_q <= 1'b1;
        end else if (axis_m.ready) begin
            m_valid_q <= 1'b0;
        end
    end

    // Payload is don't-care while invalid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            m_last_q <= axis_s.last;
            m_data_q <= axis_s.data;
            m_keep_q <= axis_s.keep;
            m_user_q <= axis_s.user;
            m_id_q   <= axis_s.id;
        end
    end

    assign axis_s.ready = s_ready;
    assign axis_m.valid = m_valid_q;
    assign axis_m.last  = m_last_q;
    assign axis_m.data  = m_data_q;
    assign axis_m.keep  = m_keep_q;
    assign axis_m.user  = m_user_q;
    assign axis_m.id    = m_id_q;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_frame_rate_shaper.sv
// Directed bench for frame_rate_shaper with a queue scoreboard: accepted
// input beats are queued as expected output, and a monitor process compares
// every output transfer, its one-cycle latency and hold stability.
module tb_frame_rate_shaper;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic [63:0]  user;
        logic [2:0]   id;
        logic         last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] gap_cycles = '0;
    logic [31:0] frame_count;
    logic [31:0] gap_count;
    logic        busy;

    logic rdy_mode = 1'b0;
    logic rdy_val  = 1'b1;
    logic tog      = 1'b0;
    int   tcnt     = 0;
    int   cyc      = 0;

    int checks = 0;
    int errors = 0;
    int frames_seen = 0;

    beat_t exp_q[$];
    int    acc_q[$];

    frame_rate_shaper_if #(.DATA_WIDTH(512)) s_if ();
    frame_rate_shaper_if #(.DATA_WIDTH(512)) m_if ();

    assign m_if.ready = rdy_mode ? tog : rdy_val;

    frame_rate_shaper #(
        .DATA_WIDTH(512),
        .GAP_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .gap_cycles (gap_cycles),
        .axis_s     (s_if),
        .axis_m     (m_if),
        .frame_count(frame_count),
        .gap_count  (gap_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tcnt == 2) begin
            tcnt <= 0;
            tog  <= ~tog;
        end else begin
            tcnt <= tcnt + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic beat_t mk(input int f, input int b, input bit last, input int nbytes);
        beat_t       x;
        logic [31:0] w;
        w      = 32'(f * 16 + b) ^ 32'hA5A5_0000;
        x.data = {16{w}};
        x.keep = (nbytes >= 64) ? '1 : ((64'd1 << nbytes) - 64'd1);
        x.user = {w, ~w};
        x.id   = 3'(f + b);
        x.last = last;
        return x;
    endfunction

    // Drives one beat from posedge+1, waits for acceptance, returns at posedge+1
    // after the accepting edge.
    task automatic send_beat(input beat_t b, output int stall);
        bit done;
        done        = 1'b0;
        stall       = 0;
        s_if.data   = b.data;
        s_if.keep   = b.keep;
        s_if.user   = b.user;
        s_if.id     = b.id;
        s_if.last   = b.last;
        s_if.valid  = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (s_if.ready === 1'b1) begin
                exp_q.push_back(b);
                acc_q.push_back(cyc);
                done = 1'b1;
            end else begin
                stall++;
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: beat id=%0h not accepted, required acceptance within 64 cycles", b.id);
        end
        @(posedge clk);
        #1;
        s_if.valid = 1'b0;
    endtask

    // 100-byte frames: a full 64-byte beat followed by a 36-byte last beat.
    task automatic send_frame(input int f, input int nbeats, output int first_stall, output int rest_stall);
        int st;
        rest_stall = 0;
        first_stall = 0;
        for (int b = 0; b < nbeats; b++) begin
            send_beat(mk(f, b, (b == nbeats - 1), (b == nbeats - 1) ? 36 : 64), st);
            if (b == 0) first_stall = st;
            else rest_stall += st;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    initial begin
        int    fs, rs, tot, seen0;
        int    exp_first[4];
        beat_t b;

        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
        s_if.data  = '0;
        s_if.keep  = '0;
        s_if.user  = '0;
        s_if.id    = '0;

        // Scoreboard monitor: samples on the falling edge, away from the active edge.
        fork
            begin
                bit    hold_prev;
                beat_t held, got, e;
                hold_prev = 1'b0;
                forever begin
                    @(negedge clk);
                    got.data = m_if.data;
                    got.keep = m_if.keep;
                    got.user = m_if.user;
                    got.id   = m_if.id;
                    got.last = m_if.last;
                    if (rst !== 1'b1) begin
                        hold_prev = 1'b0;
                    end else begin
                        if (hold_prev) begin
                            checks++;
                            if (m_if.valid !== 1'b1 || got !== held) begin
                                errors++;
                                $display("FAIL hold_stable: got valid=%b id=%h user=%h, required valid=1 id=%h user=%h",
                                         m_if.valid, got.id, got.user, held.id, held.user);
                            end
                        end
                        if (m_if.valid === 1'b1 && !hold_prev) begin
                            checks++;
                            if (acc_q.size() == 0) begin
                                errors++;
                                $display("FAIL unexpected_beat: got id=%h user=%h, required no output", got.id, got.user);
                            end else if (cyc != acc_q[0] + 1) begin
                                errors++;
                                $display("FAIL latency: got %0d cycles, required 1", cyc - acc_q[0]);
                            end
                        end
                        if (m_if.valid === 1'b1 && m_if.ready === 1'b1) begin
                            if (exp_q.size() > 0) begin
                                checks++;
                                e = exp_q.pop_front();
                                void'(acc_q.pop_front());
                                if (got !== e) begin
                                    errors++;
                                    $display("FAIL beat_payload: got data=%h keep=%h user=%h id=%h last=%b, required data=%h keep=%h user=%h id=%h last=%b",
                                             got.data, got.keep, got.user, got.id, got.last,
                                             e.data, e.keep, e.user, e.id, e.last);
                                end
                            end
                            if (got.last === 1'b1) frames_seen++;
                            hold_prev = 1'b0;
                        end else if (m_if.valid === 1'b1) begin
                            hold_prev = 1'b1;
                            held      = got;
                        end else begin
                            hold_prev = 1'b0;
                        end
                    end
                end
            end
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("reset_m_valid", 64'(m_if.valid), 64'd0);
        chk("reset_s_ready", 64'(s_if.ready), 64'd0);
        chk("reset_frame_count", 64'(frame_count), 64'd0);
        chk("reset_gap_count", 64'(gap_count), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);

        // start and stop together in IDLE: stop wins
        start = 1'b1;
        pulse_stop();
        start = 1'b0;
        chk("start_stop_same_busy", 64'(busy), 64'd0);

        // No gap, back-to-back 2-beat frames
        gap_cycles = 16'd0;
        rdy_val    = 1'b1;
        seen0      = frames_seen;
        pulse_start();
        chk("A_busy_after_start", 64'(busy), 64'd1);
        tot = 0;
        for (int f = 0; f < 4; f++) begin
            send_frame(f, 2, fs, rs);
            tot += fs + rs;
        end
        chk("A_backtoback_stall", 64'(tot), 64'd0);
        chk("A_frame_count", 64'(frame_count), 64'd4);
        chk("A_gap_count", 64'(gap_count), 64'd0);
        pulse_stop();
        chk("A_stop_idle_busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("A_frames_seen", 64'(frames_seen - seen0), 64'd4);

        // Gap of 5 after each frame; a start pulse in GAP is ignored
        gap_cycles   = 16'd5;
        exp_first[0] = 0;
        exp_first[1] = 5;
        exp_first[2] = 4;
        exp_first[3] = 5;
        pulse_start();
        chk("B_frame_count_cleared", 64'(frame_count), 64'd0);
        for (int f = 0; f < 4; f++) begin
            send_frame(10 + f, 2, fs, rs);
            chk($sformatf("B_gap_stall_f%0d", f), 64'(fs), 64'(exp_first[f]));
            chk($sformatf("B_mid_stall_f%0d", f), 64'(rs), 64'd0);
            if (f == 1) begin
                pulse_start();
                chk("B_start_in_gap_count", 64'(frame_count), 64'd2);
                chk("B_start_in_gap_busy", 64'(busy), 64'd1);
            end
        end
        repeat (5) @(posedge clk);
        #1;
        chk("B_gap_count", 64'(gap_count), 64'd20);
        chk("B_frame_count", 64'(frame_count), 64'd4);
        pulse_stop();
        chk("B_stop_busy", 64'(busy), 64'd0);

        // Downstream ready toggling every 3 cycles
        gap_cycles = 16'd0;
        seen0      = frames_seen;
        rdy_mode   = 1'b1;
        pulse_start();
        for (int f = 0; f < 4; f++) begin
            send_frame(20 + f, 2, fs, rs);
        end
        repeat (8) @(posedge clk);
        #1;
        rdy_mode = 1'b0;
        rdy_val  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("C_frames_seen", 64'(frames_seen - seen0), 64'd4);
        chk("C_frame_count", 64'(frame_count), 64'd4);
        chk("C_queue_drained", 64'(exp_q.size()), 64'd0);
        pulse_stop();

        // stop on the first beat of a frame: DRAIN passes the second beat
        pulse_start();
        stop = 1'b1;
        send_beat(mk(30, 0, 1'b0, 64), fs);
        stop = 1'b0;
        chk("D_drain_busy", 64'(busy), 64'd1);
        chk("D_drain_s_ready", 64'(s_if.ready), 64'd1);
        send_beat(mk(30, 1, 1'b1, 36), rs);
        chk("D_drain_second_stall", 64'(rs), 64'd0);
        chk("D_idle_busy", 64'(busy), 64'd0);
        chk("D_idle_s_ready", 64'(s_if.ready), 64'd0);
        chk("D_frame_count", 64'(frame_count), 64'd1);

        // stop in GAP with 3 cycles left
        gap_cycles = 16'd10;
        pulse_start();
        send_frame(40, 2, fs, rs);
        repeat (7) @(posedge clk);
        #1;
        chk("E_in_gap_busy", 64'(busy), 64'd1);
        chk("E_in_gap_s_ready", 64'(s_if.ready), 64'd0);
        pulse_stop();
        chk("E_after_stop_busy", 64'(busy), 64'd0);
        chk("E_after_stop_s_ready", 64'(s_if.ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("E_queue_drained", 64'(exp_q.size()), 64'd0);

        // Reset while a beat is held with downstream stalled
        gap_cycles = 16'd2;
        pulse_start();
        send_beat(mk(50, 0, 1'b1, 64), fs);
        repeat (3) @(posedge clk);
        #1;
        rdy_val = 1'b0;
        send_beat(mk(51, 0, 1'b0, 64), fs);
        chk("F_held_valid", 64'(m_if.valid), 64'd1);
        chk("F_pre_frame_count", 64'(frame_count), 64'd1);
        chk("F_pre_gap_count", 64'(gap_count), 64'd2);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        acc_q.delete();
        chk("F_reset_m_valid", 64'(m_if.valid), 64'd0);
        chk("F_reset_frame_count", 64'(frame_count), 64'd0);
        chk("F_reset_gap_count", 64'(gap_count), 64'd0);
        chk("F_reset_busy", 64'(busy), 64'd0);
        rdy_val = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("F_no_output_after_reset", 64'(m_if.valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_rate_shaper.md
FRAME_RATE_SHAPER -- requirements
Module: frame_rate_shaper

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, AXI-Stream data width in bits.
REQ-002 SHALL have parameter GAP_WIDTH, default 16, width of the gap configuration and gap counter.
REQ-003 clk  input  1  sole clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-low.
REQ-005 start  input  1  one-cycle pulse that begins shaping.
REQ-006 stop  input  1  one-cycle pulse that ends shaping at the next frame boundary.
REQ-007 gap_cycles  input  GAP_WIDTH  number of idle input cycles inserted after each frame; sampled when each frame's last beat is accepted.
REQ-008 axis_s_valid/ready/last  in/out/in  1 each  upstream handshake, fed by the frame generator.
REQ-009 axis_s_data/keep/user/id  input  DATA_WIDTH/DATA_WIDTH/8/DATA_WIDTH/8/3  upstream beat payload.
REQ-010 axis_m_valid/ready/last  out/in/out  1 each  downstream handshake, toward the frame checker path.
REQ-011 axis_m_data/keep/user/id  output  same widths as the s-side  registered beat payload.
REQ-012 frame_count  output  32  number of frames whose last beat was accepted since the last start.
REQ-013 gap_count  output  32  number of gap cycles spent in GAP since the last start.
REQ-014 busy  output  1  high in every state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, PASS, GAP and DRAIN.
REQ-016 IDLE: axis_s_ready=0; start moves to PASS and clears both counters in the same edge.
REQ-017 PASS: axis_s_ready = !axis_m_valid || axis_m_ready (one-entry output register, full throughput).
REQ-018 Accepted beat (axis_s_valid && axis_s_ready) SHALL appear on axis_m_* exactly 1 cycle later, with all fields unchanged.
REQ-019 axis_m_valid SHALL stay high, with payload stable, until axis_m_ready is high.
REQ-020 When a last beat is accepted: frame_count+1; if gap_cycles==0, stay in PASS; otherwise load the counter with gap_cycles and go to GAP.
REQ-021 GAP: axis_s_ready=0 for exactly gap_cycles cycles, gap_count+1 per cycle, then return to PASS.
REQ-022 The output register SHALL continue to drain in GAP; axis_m_valid is independent of the state.
REQ-023 stop in PASS while not mid-frame (no beat accepted since the last last-beat): go to IDLE next cycle.
REQ-024 stop mid-frame: go to DRAIN; DRAIN behaves as PASS until the last beat is accepted, then goes to IDLE, with no gap.
REQ-025 stop in GAP: go to IDLE immediately and abandon the remaining gap.
REQ-026 stop and start in the same cycle: stop wins; start is ignored.
REQ-027 start outside IDLE: ignored.
REQ-028 An in-flight output beat SHALL still be presented in IDLE until accepted.
REQ-029 Counters wrap modulo 2^32 without saturation.
REQ-030 The gap counter SHALL be GAP_WIDTH bits, count down and never underflow.

Reset
REQ-031 When rst=0 at a clock edge, the block SHALL return to IDLE.
REQ-032 Reset values: axis_m_valid=0, axis_s_ready=0, frame_count=0, gap_count=0, busy=0, gap counter=0.
REQ-033 Reset SHALL discard any held output beat.
REQ-034 Reset mid-frame SHALL discard the rest of that frame with no recovery.
REQ-035 axis_m_data/keep/user/id/last SHALL be don't-care while axis_m_valid=0.

Verification
REQ-036 gap_cycles=0, 100-byte frames (2 beats), m_ready=1: back-to-back beats, 1-cycle latency, frame_count=4 after 4 frames.
REQ-037 gap_cycles=5: exactly 5 cycles of s_ready=0 after each last beat; gap_count=20 after 4 frames.
REQ-038 m_ready toggling every 3 cycles (period 6): payload is held stable and nothing is dropped or duplicated; the checker sees 4 intact frames.
REQ-039 stop on the first beat of a 2-beat frame: DRAIN passes the second beat, then IDLE; frame_count incremented once.
REQ-040 stop during GAP with 3 cycles left: next cycle IDLE, busy=0, s_ready=0.
REQ-041 rst=0 while a beat is held with m_ready=0: next cycle m_valid=0 and both counters are 0.
